sample_frame_packer: RTL and testbench

//  Upstream stage of the sample memory buffer. Collects 24-bit ADC samples from a valid/ready stream.

---
 rtl/sample_frame_packer.sv | 125 ++++++++++++
 tb/tb_sample_frame_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_packer.sv
// sample_frame_packer: packs 24-bit samples MSB-first into 768-bit frames.
// Frames close when full, on flush, on idle timeout or at the sample cap.
module sample_frame_packer #(
    parameter int SAMPLE_W      = 24,
    parameter int FRAME_SAMPLES = 32,
    parameter int MAX_TOTAL     = 3750,
    parameter int IDLE_TIMEOUT  = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SAMPLE_W-1:0]               s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic                              flush,
    output logic [SAMPLE_W*FRAME_SAMPLES-1:0] fifo_data,
    output logic [5:0]                        num_samples,
    output logic                              data_ready,
    output logic [12:0]                       total_count,
    output logic                              cap_reached
);

    localparam int FRAME_W = SAMPLE_W * FRAME_SAMPLES;
    localparam int IDLE_W  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic {
        FILL,
        CAPPED
    } state_t;

    state_t              state;
    logic [FRAME_W-1:0]  pack;
    logic [5:0]          fill;
    logic [IDLE_W-1:0]   idle;

    logic                accept;
    logic [FRAME_W-1:0]  pack_nxt;
    logic [5:0]          fill_nxt;
    logic [IDLE_W-1:0]   idle_nxt;
    logic [12:0]         total_nxt;
    logic                close_full;
    logic                close_flush;
    logic                close_idle;
    logic                close_cap;
    logic                close;

    assign accept = s_valid && s_ready;

    // Next-state view of the frame including this edge's sample.
    always_comb begin
        pack_nxt  = pack;
        fill_nxt  = fill;
        idle_nxt  = idle;
        total_nxt = total_count;
        if (accept) begin
            for (int k = 0; k < FRAME_SAMPLES; k++) begin
                if (fill == 6'(k)) begin
                    pack_nxt[FRAME_W-1-SAMPLE_W*k -: SAMPLE_W] = s_data;
                end
            end
            fill_nxt  = fill + 6'd1;
            idle_nxt  = '0;
            total_nxt = total_count + 13'd1;
        end else if (fill != 6'd0 && IDLE_TIMEOUT != 0) begin
            idle_nxt = idle + IDLE_W'(1);
        end else begin
            idle_nxt = '0;
        end
    end

    // Frame close conditions, evaluated on the post-accept view.
    always_comb begin
        close_full  = (fill_nxt == 6'(FRAME_SAMPLES));
        close_flush = flush && (state == FILL) && (fill_nxt != 6'd0);
        close_idle  = (IDLE_TIMEOUT != 0) && !accept && (fill_nxt != 6'd0)
                      && (idle_nxt == IDLE_W'(IDLE_TIMEOUT));
        close_cap   = accept && (total_nxt == 13'(MAX_TOTAL));
        close       = close_full || close_flush || close_idle || close_cap;
    end

    // Packing state, output frame registers and the FILL/CAPPED machine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            pack        <= '0;
            fill        <= '0;
            idle        <= '0;
            fifo_data   <= '0;
            num_samples <= '0;
            data_ready  <= 1'b0;
            total_count <= '0;
            cap_reached <= 1'b0;
            s_ready     <= 1'b1;
        end else begin
            total_count <= total_nxt;
            if (close) begin
                fifo_data   <= pack_nxt;
                num_samples <= fill_nxt;
                data_ready  <= 1'b1;
                pack        <= '0;
                fill        <= '0;
                idle        <= '0;
            end else begin
                data_ready  <= 1'b0;
                pack        <= pack_nxt;
                fill        <= fill_nxt;
                idle        <= idle_nxt;
            end
            unique case (state)
                FILL: begin
                    if (close_cap) begin
                        state       <= CAPPED;
                        cap_reached <= 1'b1;
                        s_ready     <= 1'b0;
                    end
                end
                CAPPED: begin
                    cap_reached <= 1'b1;
                    s_ready     <= 1'b0;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_frame_packer.sv
// tb_sample_frame_packer: directed checks of frame packing, close
// conditions, capacity cap and reset behaviour.
module tb_sample_frame_packer;

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic          flush;
    logic [767:0]  fifo_data;
    logic [5:0]    num_samples;
    logic          data_ready;
    logic [12:0]   total_count;
    logic          cap_reached;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            strobes = 0;
    logic [5:0]    last_n;
    logic [767:0]  last_d;
    logic [767:0]  ef;

    sample_frame_packer dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .flush       (flush),
        .fifo_data   (fifo_data),
        .num_samples (num_samples),
        .data_ready  (data_ready),
        .total_count (total_count),
        .cap_reached (cap_reached)
    );

    always #5 clk = ~clk;

    // Record every frame strobe just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (data_ready) begin
            strobes = strobes + 1;
            last_n  = num_samples;
            last_d  = fifo_data;
        end
    end

    task automatic chk(input string tag, input logic [767:0] got,
                       input logic [767:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [23:0] d);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        flush   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            flush   = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        flush   = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        flush   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_data",  fifo_data,   768'd0);
        chk("rst_num",   num_samples, 768'd0);
        chk("rst_dr",    data_ready,  768'd0);
        chk("rst_total", total_count, 768'd0);
        chk("rst_cap",   cap_reached, 768'd0);
        chk("rst_ready", s_ready,     768'd1);

        // Full frame of 32 back-to-back samples
        for (int i = 1; i <= 32; i++) push(24'(i));
        idle(2);
        ef = '0;
        for (int k = 0; k < 32; k++) ef[767-24*k -: 24] = 24'(k + 1);
        chk("full_strobes", strobes, 768'd1);
        chk("full_num", last_n, 768'd32);
        chk("full_first", last_d[767:744], 768'h000001);
        chk("full_last", last_d[23:0], 768'h000020);
        chk("full_frame", last_d, ef);
        chk("full_dr_low", data_ready, 768'd0);
        chk("full_total", total_count, 768'd32);

        // Five samples then a flush pulse
        strobes = 0;
        for (int i = 0; i < 5; i++) push(24'hA00001 + 24'(i));
        @(negedge clk);
        s_valid = 1'b0;
        flush   = 1'b1;
        idle(2);
        ef = '0;
        for (int k = 0; k < 5; k++) ef[767-24*k -: 24] = 24'hA00001 + 24'(k);
        chk("flush_strobes", strobes, 768'd1);
        chk("flush_num", last_n, 768'd5);
        chk("flush_tail0", last_d[647:0], 768'd0);
        chk("flush_frame", last_d, ef);

        // Three samples then idle timeout
        strobes = 0;
        for (int i = 0; i < 3; i++) push(24'h300000 + 24'(i));
        idle(64);
        chk("idle_early", strobes, 768'd0);
        idle(1);
        chk("idle_strobes", strobes, 768'd1);
        chk("idle_num", last_n, 768'd3);
        chk("idle_slot2", last_d[719:696], 768'h300002);
        chk("idle_slot3", last_d[695:672], 768'd0);

        // Flush with an empty frame is ignored
        @(negedge clk);
        flush = 1'b1;
        idle(3);
        chk("empty_flush", strobes, 768'd1);

        // Flush in the same cycle as the 10th accept
        strobes = 0;
        for (int i = 0; i < 9; i++) push(24'h400000 + 24'(i));
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 24'hBEEF10;
        flush   = 1'b1;
        idle(2);
        chk("flacc_strobes", strobes, 768'd1);
        chk("flacc_num", last_n, 768'd10);
        chk("flacc_slot9", last_d[551:528], 768'hBEEF10);
        chk("flacc_slot8", last_d[575:552], 768'h400008);
        chk("flacc_slot10", last_d[527:504], 768'd0);

        // Reset mid-frame discards the partial frame
        strobes = 0;
        for (int i = 0; i < 7; i++) push(24'h700000 + 24'(i));
        do_reset();
        chk("rst7_total", total_count, 768'd0);
        for (int i = 1; i <= 32; i++) push(24'h500000 + 24'(i));
        idle(70);
        chk("rst7_strobes", strobes, 768'd1);
        chk("rst7_num", last_n, 768'd32);
        chk("rst7_first", last_d[767:744], 768'h500001);
        chk("rst7_total32", total_count, 768'd32);

        // Continuous stream past the capacity cap
        do_reset();
        strobes = 0;
        for (int i = 1; i <= 3760; i++) begin
            push(24'(i));
            if (i == 3750) chk("cap_ready_before", s_ready, 768'd1);
            if (i == 3751) chk("cap_ready_after", s_ready, 768'd0);
            if (i == 3751) chk("cap_flag_edge", cap_reached, 768'd1);
        end
        idle(2);
        ef = '0;
        for (int k = 0; k < 6; k++) ef[767-24*k -: 24] = 24'(3745 + k);
        chk("cap_strobes", strobes, 768'd118);
        chk("cap_last_num", last_n, 768'd6);
        chk("cap_last_frame", last_d, ef);
        chk("cap_flag", cap_reached, 768'd1);
        chk("cap_ready", s_ready, 768'd0);
        chk("cap_total", total_count, 768'd3750);

        // Flush and samples are ignored while capped
        @(negedge clk);
        flush   = 1'b1;
        s_valid = 1'b1;
        idle(3);
        chk("cap_flush_ign", strobes, 768'd118);
        chk("cap_total_hold", total_count, 768'd3750);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
